// File: rtl/mpmc12_resv_table_pkg.sv
// Shared types and helpers for the LR/SC reservation table.
// The entry field widths are taken from the constants below.
package mpmc12_resv_table_pkg;

  localparam int NAR_DEF = 8;
  localparam int NCH_DEF = 16;
  localparam int CHW     = $clog2(NCH_DEF);
  localparam int AW      = 32;
  localparam int GRAN    = 5;
  localparam int TW      = 10;
  localparam int TGW     = AW - GRAN;

  typedef struct packed {
    logic           v;
    logic [CHW-1:0] ch;
    logic [TGW-1:0] tag;
    logic [TW-1:0]  age;
  } resv_entry_t;

  function automatic logic [TGW-1:0] f_granule(input logic [AW-1:0] adr);
    return TGW'(adr >> GRAN);
  endfunction

endpackage

// File: rtl/mpmc12_resv_table_if.sv
// Granted-request, flush and SC-response bundle between the arbiter and the reservation table.
interface mpmc12_resv_table_if #(
  parameter int NCH = 16,
  parameter int NAR = 8
);
  import mpmc12_resv_table_pkg::*;

  logic                  req;
  logic [CHW-1:0]        req_ch;
  logic                  req_we;
  logic                  req_cr;
  logic                  req_rsv;
  logic [AW-1:0]         req_adr;
  logic [NCH-1:0]        flush;
  logic                  resp_v;
  logic                  resp_ok;
  logic [CHW-1:0]        resp_ch;
  logic [$clog2(NAR):0]  resv_cnt;

  modport master (
    output req, req_ch, req_we, req_cr, req_rsv, req_adr, flush,
    input  resp_v, resp_ok, resp_ch, resv_cnt
  );

  modport slave (
    input  req, req_ch, req_we, req_cr, req_rsv, req_adr, flush,
    output resp_v, resp_ok, resp_ch, resv_cnt
  );

endinterface

// File: rtl/mpmc12_resv_table_entry.sv
// One reservation entry: register, saturating age, address/channel compares and kill logic.
module mpmc12_resv_table_entry
  import mpmc12_resv_table_pkg::*;
#(
  parameter int NCH = 16,
  parameter int TMO = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TGW-1:0] gran_i,
  input  logic [CHW-1:0] ch_i,
  input  logic [NCH-1:0] flush_i,
  input  logic           ld_i,
  input  logic           sc_i,
  input  logic           sc_ok_i,
  input  logic           wr_i,
  output logic           v_o,
  output logic           own_o,
  output logic           chhit_o
);

  resv_entry_t e_q, e_d;
  logic        match;
  logic        expire;
  logic        kill;

  assign match   = e_q.v && (e_q.tag == gran_i);
  assign chhit_o = e_q.v && (e_q.ch == ch_i);
  assign own_o   = match && (e_q.ch == ch_i);
  assign v_o     = e_q.v;
  assign expire  = (TMO != 0) && e_q.v && (e_q.age == TW'(TMO));

  // An SC always drops the requester's reservation; a passing SC also drops everyone's copy of that granule.
  assign kill = (wr_i && match) || (sc_i && chhit_o) || (sc_i && sc_ok_i && match) ||
                flush_i[e_q.ch] || expire;

  always_comb begin
    e_d = e_q;
    if (e_q.v && (e_q.age != TW'(TMO))) e_d.age = e_q.age + TW'(1);
    if (kill) e_d.v = 1'b0;
    if (ld_i) begin
      e_d.v   = 1'b1;
      e_d.ch  = ch_i;
      e_d.tag = gran_i;
      e_d.age = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) e_q.v <= 1'b0;
    else     e_q.v <= e_d.v;
    e_q.ch  <= e_d.ch;
    e_q.tag <= e_d.tag;
    e_q.age <= e_d.age;
  end

endmodule

// File: rtl/mpmc12_resv_table.sv
// LR/SC reservation table: allocation, round-robin eviction, SC check and registered SC response.
module mpmc12_resv_table
  import mpmc12_resv_table_pkg::*;
#(
  parameter int NAR = NAR_DEF,
  parameter int NCH = NCH_DEF,
  parameter int TMO = 1023
) (
  input  logic             clk,
  input  logic             rst,
  mpmc12_resv_table_if.slave rt
);

  localparam int PW = $clog2(NAR);

  logic [TGW-1:0] gran;
  logic           lr, sc, wr;
  logic           sc_ok;
  logic [NAR-1:0] v_vec, own_vec, chhit_vec, ld_vec;
  logic [PW-1:0]  vic_q, vic_d;
  logic [PW-1:0]  low_inv;
  logic [PW:0]    cnt;
  logic           resp_v_q, resp_ok_q;
  logic [CHW-1:0] resp_ch_q;

  assign gran  = f_granule(rt.req_adr);
  assign lr    = rt.req && !rt.req_we && rt.req_rsv;
  assign sc    = rt.req && rt.req_we && rt.req_cr;
  assign wr    = rt.req && rt.req_we && !rt.req_cr;
  assign sc_ok = |own_vec;

  for (genvar i = 0; i < NAR; i++) begin : g_ent
    mpmc12_resv_table_entry #(.NCH(NCH), .TMO(TMO)) u_ent (
      .clk     (clk),
      .rst     (rst),
      .gran_i  (gran),
      .ch_i    (rt.req_ch),
      .flush_i (rt.flush),
      .ld_i    (ld_vec[i]),
      .sc_i    (sc),
      .sc_ok_i (sc_ok),
      .wr_i    (wr),
      .v_o     (v_vec[i]),
      .own_o   (own_vec[i]),
      .chhit_o (chhit_vec[i])
    );
  end

  always_comb begin
    low_inv = '0;
    for (int i = NAR - 1; i >= 0; i--) begin
      if (!v_vec[i]) low_inv = PW'(i);
    end
  end

  // The channel's existing slot wins, then the lowest free slot, then the round-robin victim.
  always_comb begin
    ld_vec = '0;
    vic_d  = vic_q;
    if (lr) begin
      if (|chhit_vec) begin
        ld_vec = chhit_vec;
      end else if (!(&v_vec)) begin
        ld_vec[low_inv] = 1'b1;
      end else begin
        ld_vec[vic_q] = 1'b1;
        vic_d         = vic_q + PW'(1);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NAR; i++) cnt = cnt + (PW + 1)'(v_vec[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vic_q     <= '0;
      resp_v_q  <= 1'b0;
      resp_ok_q <= 1'b0;
      resp_ch_q <= '0;
    end else begin
      vic_q     <= vic_d;
      resp_v_q  <= sc;
      resp_ok_q <= sc && sc_ok;
      if (sc) resp_ch_q <= rt.req_ch;
    end
  end

  assign rt.resp_v   = resp_v_q;
  assign rt.resp_ok  = resp_ok_q;
  assign rt.resp_ch  = resp_ch_q;
  assign rt.resv_cnt = cnt;

endmodule

// File: doc/mpmc12_resv_table.md
Name: mpmc12_resv_table

Overview:
- Parametrised reservation table for load-reserved / store-conditional (LR/SC) atomics in the multi-port memory controller.
- Sits beside the controller's request arbiter and sees one granted request per cycle.
- Records reservations, snoops every write to kill matching reservations, and ages reservations out.
- Returns a registered pass/fail result for each store-conditional.
- Generalises the single reservation-status bit to N entries, configurable channel count, address width and granule size, with replacement, timeout and per-channel flush.

Parameters:
- NAR, 8: number of reservation entries (power of 2, ≥2).
- NCH, 16: number of requesting channels.
- CHW, $clog2(NCH): channel-ID width.
- AW, 32: byte-address width.
- GRAN, 5: log2 of the reservation granule in bytes (32-byte line).
- TMO, 1023: entry lifetime in cycles. 0 disables timeout.
- TW, 10: timeout counter width (must hold TMO).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- req, input, 1: granted request valid this cycle.
- req_ch, input, CHW: requesting channel.
- req_we, input, 1: write request.
- req_cr, input, 1: conditional store (SC); meaningful only with req_we.
- req_rsv, input, 1: load-reserved; meaningful only with !req_we.
- req_adr, input, AW: byte address.
- flush, input, NCH: per-channel reservation kill (context switch, channel reset).
- resp_v, output, 1: one-cycle pulse, SC result valid.
- resp_ok, output, 1: SC succeeded; the controller must suppress the write when resp_ok=0.
- resp_ch, output, CHW: channel of the SC result.
- resv_cnt, output, $clog2(NAR)+1: number of valid entries.

Behaviour:
- Reset: all entries invalid, victim pointer 0, resp_v=0, resp_ok=0, resp_ch=0, resv_cnt=0. Reset overrides any same-cycle request and flush.
- Entry fields: v, ch, tag = adr[AW-1:GRAN], age[TW-1:0].
- "Match" means v && tag == req_adr[AW-1:GRAN]. "Own" means match && ch == req_ch.
- At most one valid entry per channel, at all times.
- LR (req && !req_we && req_rsv), applied in the next-cycle state:
  - If the channel already holds an entry, overwrite it in place (tag, age=0).
  - Else allocate the lowest-index invalid entry.
  - Else evict the entry at the victim pointer and increment the pointer mod NAR.
  - Plain reads (req_rsv=0) do not change the table.
- SC (req && req_we && req_cr):
  - resp_ok = OR of Own over all entries.
  - The channel's own entry is always invalidated, pass or fail.
  - On pass, every other Match entry (other channels) is also invalidated.
  - On fail, other channels' entries are untouched.
  - resp_v/resp_ok/resp_ch are registered: valid exactly 1 cycle after the req cycle, and resp_v lasts 1 cycle.
  - Back-to-back SCs give back-to-back resp_v pulses.
- Plain write (req && req_we && !req_cr): invalidate every Match entry, all channels including the writer. No response.
- Timeout (TMO≠0):
  - Each valid entry increments age every cycle.
  - An entry with age==TMO is invalidated that cycle.
  - An SC checked in the same cycle that the entry expires sees the entry as still valid, so an SC at age TMO passes.
- Flush: every entry whose flush[ch]=1 is invalidated.
- Same-cycle priority, applied to next state in this order: rst > flush > timeout > LR allocate. Invalidations from writes/SC use current-cycle state.
  - An LR from a flushed channel in the same cycle still allocates, so the new reservation survives.
  - An LR whose tag equals a granule written in the same cycle is impossible: there is one request per cycle.
- Counters:
  - age saturates at TMO and never wraps.
  - The victim pointer wraps NAR-1 → 0.
  - resv_cnt is combinational popcount of v.
- req while rst=1: ignored, no resp_v.

Decomposition:
- mpmc12_pkg holds:
  - resv_entry_t packed struct {v, ch, tag, age}, parameterised via the package's AW/GRAN/CHW constants;
  - the NAR/NCH defaults;
  - the function f_granule(adr) returning adr[AW-1:GRAN].
- One sub-module, mpmc12_resv_entry:
  - holds a single entry register, its age counter, the match/own compares and its kill logic;
  - instantiated NAR times.
- The top holds allocation, the victim pointer, the SC OR-reduce and the response register.

Test Plan:
- LR ch3 @0x1000; SC ch3 @0x101C 10 cycles later → resp_v 1 cycle after, resp_ok=1, resp_ch=3; resv_cnt 1→0.
- LR ch3 @0x1000; plain write ch5 @0x1010; SC ch3 @0x1000 → resp_ok=0. LR ch3 @0x1000; write ch5 @0x1020 (different granule); SC ch3 @0x1000 → resp_ok=1.
- LR ch1 @0x2000 and LR ch2 @0x2000; SC ch1 passes → ch2 entry killed, SC ch2 @0x2000 → resp_ok=0. Repeat with SC ch1 @0x3000 failing → ch2 SC then passes.
- NAR=8: LR from ch0..ch8 on distinct granules → ch0 evicted (victim 0→1), resv_cnt=8; SC ch0 fails; SC ch8 passes.
- TMO=15: LR ch4; SC at age 15 → pass. LR ch4, wait 16 cycles, SC → fail; resv_cnt drops at the expiry cycle.
- flush[6]=1 together with LR ch6 @0x4000 while ch6 holds @0x5000 → SC ch6 @0x4000 passes. Assert rst during a pending SC → no resp_v, resv_cnt=0.
